branch_resolve_unit: RTL

Execute-stage branch resolution for the 64-bit pipelined ARM core. Consumes the ALU zero flag (from the zero-detect tree on the ALU result) plus N/C/V and maintains the architectural NZCV register. Decides CBZ/CBNZ/B.cond/B outcomes, computes the target, and drives a registered redirect with a one-cycle flush of the younger IF/ID/EX stages.

---
 rtl/branch_pkg.sv | 43 ++++
 rtl/branch_resolve_unit_cond_eval.sv | 50 +++++
 rtl/branch_resolve_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch-resolution types: branch kinds, ARM condition codes, NZCV bit positions.
// Also imported by the conditional-select datapath, which reuses cond_eval.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_UNCOND = 3'd1,
        BR_CBZ    = 3'd2,
        BR_CBNZ   = 3'd3,
        BR_COND   = 3'd4
    } br_kind_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// ARM condition-code evaluator: cond + NZCV -> pass.
// Purely combinational, zero latency; no flow control.
// Stateless, so it has no backpressure behaviour of its own.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;
    logic hi;
    logic ge;
    logic gt;

    assign n  = nzcv[FLAG_N];
    assign z  = nzcv[FLAG_Z];
    assign c  = nzcv[FLAG_C];
    assign v  = nzcv[FLAG_V];
    assign hi = c & ~z;
    assign ge = (n == v);
    assign gt = ~z & ge;

    // AL and NV both fall through to the default: NV executes as always on AArch64
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_HS: pass = c;
            COND_LO: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = hi;
            COND_LS: pass = ~hi;
            COND_GE: pass = ge;
            COND_LT: pass = ~ge;
            COND_GT: pass = gt;
            COND_LE: pass = ~gt;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: NZCV register, taken decision, target add, redirect/flush FSM.
// Latency: taken branch in EX at cycle t -> registered redirect/flush in t+1, held for one cycle.
// Backpressure: stall freezes all state and outputs, so a pending redirect is held through it.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic                  stall,
    input  logic [2:0]            br_kind,
    input  logic [3:0]            cond,
    input  logic                  set_flags,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
    input  logic                  alu_carry,
    input  logic                  alu_ovf,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic [ADDR_WIDTH-1:0] br_offset,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic [3:0]            flags_q,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    fsm_state_t            state;
    logic                  cond_pass;
    logic                  br_taken;
    logic                  live;
    logic [3:0]            alu_nzcv;
    logic [ADDR_WIDTH-1:0] target;

    // B.cond sees the flags committed at the previous edge, never the same-cycle ALU flags
    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    always_comb begin
        alu_nzcv         = 4'b0000;
        alu_nzcv[FLAG_N] = alu_neg;
        alu_nzcv[FLAG_Z] = alu_zero;
        alu_nzcv[FLAG_C] = alu_carry;
        alu_nzcv[FLAG_V] = alu_ovf;
    end

    always_comb begin
        br_taken = 1'b0;
        case (br_kind)
            BR_UNCOND: br_taken = 1'b1;
            BR_CBZ:    br_taken = alu_zero;
            BR_CBNZ:   br_taken = ~alu_zero;
            BR_COND:   br_taken = cond_pass;
            default:   br_taken = 1'b0;
        endcase
    end

    assign live   = ex_valid & ~stall & (state == RUN);
    assign target = pc_ex + br_offset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            flags_q     <= 4'b0000;
            taken_count <= '0;
        end else if (!stall) begin
            if (state == FLUSH) begin
                // EX holds wrong-path work this cycle; drop it and resume
                state    <= RUN;
                redirect <= 1'b0;
                flush    <= 1'b0;
            end else if (live) begin
                if (set_flags) begin
                    flags_q <= alu_nzcv;
                end
                if (br_taken) begin
                    state       <= FLUSH;
                    redirect    <= 1'b1;
                    flush       <= 1'b1;
                    redirect_pc <= target;
                    if (taken_count != '1) begin
                        taken_count <= taken_count + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
